// File: rtl/fp_add_result_buffer.sv
// fp_add_result_buffer: FIFO stage after the fp adder; tags results, derives {NV,OF,UF}.
// Ports: in_* push side, out_* pop side, count, fflags/fflags_clr (FP_RESULT_STICKY_FLAGS_EN).
module fp_add_result_buffer #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_result,
  input  logic                     in_overflow,
  input  logic                     in_underflow,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [2:0]               out_flags,
  output logic [TAG_W-1:0]         out_tag,
  output logic [2:0]               fflags,
  input  logic                     fflags_clr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]      res_q [DEPTH];
  logic [2:0]       flg_q [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push;
  logic          pop;
  logic [2:0]    in_flags;

  // Only the canonical quiet NaN marks an invalid op.
  assign in_flags = {in_result == 32'h7FC0_0000,
                     in_overflow,
                     in_underflow};

  // Both derived from registered count only.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  assign out_result = res_q[rptr];
  assign out_flags  = flg_q[rptr];
  assign out_tag    = tag_q[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        res_q[i] <= '0;
        flg_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      if (push) begin
        res_q[wptr] <= in_result;
        flg_q[wptr] <= in_flags;
        tag_q[wptr] <= in_tag;
        wptr        <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

`ifdef FP_RESULT_STICKY_FLAGS_EN
  // Flags retire with the entry; a popped entry survives a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags <= '0;
    end else begin
      fflags <= (fflags_clr ? 3'b000 : fflags)
              | (pop ? out_flags : 3'b000);
    end
  end
`else
  logic unused_fflags_clr;
  assign unused_fflags_clr = fflags_clr;
  assign fflags = 3'b000;
`endif

endmodule

// File: tb/tb_fp_add_result_buffer.sv
// tb_fp_add_result_buffer: queue-model bench for fp_add_result_buffer.
// Directed literal checks plus randomized traffic compared every cycle.
module tb_fp_add_result_buffer;

  localparam int TAG_W = 4;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef FP_RESULT_STICKY_FLAGS_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_result = '0;
  logic             in_overflow = 1'b0;
  logic             in_underflow = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_result;
  logic [2:0]       out_flags;
  logic [TAG_W-1:0] out_tag;
  logic [2:0]       fflags;
  logic             fflags_clr = 1'b0;
  logic [CW-1:0]    count;

  fp_add_result_buffer #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_overflow(in_overflow),
    .in_underflow(in_underflow), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .out_tag(out_tag), .fflags(fflags),
    .fflags_clr(fflags_clr), .count(count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an ordered queue of {result, flags, tag} plus a sticky word.
  typedef struct packed {
    logic [31:0]      res;
    logic [2:0]       flg;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t     mq[$];
  logic [2:0] m_ff = 3'b000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ff = 3'b000;
    end else begin
      bit   do_push;
      bit   do_pop;
      ent_t e;
      ent_t h;
      do_push = in_valid && (mq.size() < DEPTH);
      do_pop  = out_ready && (mq.size() > 0);
      h = '0;
      if (do_pop) h = mq[0];
      e.res = in_result;
      e.flg = {in_result == 32'h7FC00000, in_overflow, in_underflow};
      e.tag = in_tag;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
      if (STICKY)
        m_ff = (fflags_clr ? 3'b000 : m_ff) | (do_pop ? h.flg : 3'b000);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("count", 32'(count), 32'(mq.size()));
      chk("fflags", 32'(fflags), 32'(m_ff));
      if (mq.size() != 0) begin
        chk("out_result", out_result, mq[0].res);
        chk("out_flags", 32'(out_flags), 32'(mq[0].flg));
        chk("out_tag", 32'(out_tag), 32'(mq[0].tag));
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(bit v, logic [31:0] r, bit o, bit u, int t);
    in_valid     = v;
    in_result    = r;
    in_overflow  = o;
    in_underflow = u;
    in_tag       = TAG_W'(t);
  endtask

  initial begin
    // Reset state.
    repeat (2) cyc();
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_fflags", 32'(fflags), 0);
    chk("rst_out_result", out_result, 0);
    rst_n = 1'b1;

    // Single push.
    drive(1, 32'h3F800000, 0, 0, 5);
    cyc();
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_result", out_result, 32'h3F800000);
    chk("t1_tag", 32'(out_tag), 5);
    chk("t1_flags", 32'(out_flags), 0);
    drive(0, 0, 0, 0, 0);
    out_ready = 1;
    cyc();
    chk("t1_count", 32'(count), 0);

    // Backpressure at DEPTH=2.
    out_ready = 0;
    drive(1, 32'h40000000, 0, 0, 1);
    cyc();
    drive(1, 32'h40400000, 0, 0, 2);
    cyc();
    chk("bp_ready", 32'(in_ready), 0);
    drive(1, 32'h40800000, 0, 0, 3);
    cyc();
    chk("bp_hold_cnt", 32'(count), 2);
    chk("bp_head1", 32'(out_tag), 1);
    out_ready = 1;
    cyc();
    chk("bp_bubble_cnt", 32'(count), 1);
    chk("bp_head2", 32'(out_tag), 2);
    out_ready = 0;
    cyc();
    chk("bp_tag3_in", 32'(count), 2);
    drive(0, 0, 0, 0, 0);
    out_ready = 1;
    cyc();
    chk("bp_head3", 32'(out_tag), 3);
    cyc();
    chk("bp_empty", 32'(count), 0);

    // Streaming with wrap.
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h3F000000 + 32'(i), 0, 0, i);
      cyc();
      chk("st_count", 32'(count), 1);
      chk("st_tag", 32'(out_tag), 32'(i));
    end
    drive(0, 0, 0, 0, 0);
    cyc();

    // Flag accumulation.
    out_ready = 0;
    drive(1, 32'h7FC00000, 0, 0, 0);
    cyc();
    chk("nv_flags", 32'(out_flags), 3'b100);
    drive(1, 32'h7F800000, 1, 0, 1);
    cyc();
    drive(0, 0, 0, 0, 0);
    out_ready = 1;
    cyc();
    chk("ff_nv", 32'(fflags), STICKY ? 3'b100 : 3'b000);
    drive(1, 32'h00000000, 0, 1, 2);
    cyc();
    chk("ff_of", 32'(fflags), STICKY ? 3'b110 : 3'b000);
    drive(0, 0, 0, 0, 0);
    cyc();
    chk("ff_uf", 32'(fflags), STICKY ? 3'b111 : 3'b000);
    out_ready = 0;
    fflags_clr = 1;
    cyc();
    fflags_clr = 0;
    chk("ff_clr", 32'(fflags), 0);

    // Clear coinciding with pop.
    drive(1, 32'h7FC00000, 0, 0, 4);
    cyc();
    drive(1, 32'h00000001, 0, 1, 5);
    cyc();
    drive(0, 0, 0, 0, 0);
    out_ready = 1;
    repeat (2) cyc();
    chk("ff_101", 32'(fflags), STICKY ? 3'b101 : 3'b000);
    out_ready = 0;
    drive(1, 32'h7F800000, 1, 0, 6);
    cyc();
    drive(0, 0, 0, 0, 0);
    out_ready = 1;
    fflags_clr = 1;
    cyc();
    fflags_clr = 0;
    out_ready = 0;
    chk("ff_clr_pop", 32'(fflags), STICKY ? 3'b010 : 3'b000);
    fflags_clr = 1;
    cyc();
    fflags_clr = 0;

    // Async reset with entries held.
    drive(1, 32'h7FC00000, 1, 1, 7);
    repeat (2) cyc();
    drive(0, 0, 0, 0, 0);
    chk("pre_rst_cnt", 32'(count), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_ready", 32'(in_ready), 1);
    chk("arst_count", 32'(count), 0);
    chk("arst_fflags", 32'(fflags), 0);
    cyc();
    rst_n = 1'b1;
    out_ready = 1;
    cyc();
    chk("post_rst_ff", 32'(fflags), 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] r;
      r = ($urandom_range(0, 3) == 0) ? 32'h7FC00000 : $urandom;
      drive($urandom_range(0, 3) != 0, r,
            $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            int'($urandom_range(0, 15)));
      out_ready  = ($urandom_range(0, 2) != 0);
      fflags_clr = ($urandom_range(0, 15) == 0);
      cyc();
    end
    drive(0, 0, 0, 0, 0);
    fflags_clr = 0;
    out_ready = 1;
    repeat (4) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
